uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised asynchronous serial receiver. It is the successor to the fixed 8N1 receiver: data width, parity, stop-bit count and oversampling are configurable. It adds start-bit validation, framing/parity/overrun detection and a valid/ready output holding register. It sits between the rxd pad and the byte-level protocol logic, and keeps the idle/end-of-packet gap detection.

Parameters:
CLK_FREQ, 25000000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
OVERSAMPLE, 16, ticks per bit; power of 2, at least 8. Elaboration error otherwise, or if CLK_FREQ < BAUD*OVERSAMPLE.
DATA_BITS, 8, data bits per frame, range 5..9.
PARITY_MODE, 0, parity setting: 0 none, 1 even, 2 odd.
STOP_BITS, 1, stop bits checked, 1 or 2.
GAP_BITS, 16, idle bit-times before rx_idle asserts; range 2..255.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rxd  in  1  serial line; idles high; asynchronous to clk.
rx_data  out  DATA_BITS  received word, LSB first on the line; valid while rx_valid.
rx_valid  out  1  holding register full.
rx_ready  in  1  consumer accepts; transfer when rx_valid && rx_ready.
frame_err  out  1  status of held word: stop bit sampled low. Valid with rx_valid.
parity_err  out  1  status of held word: parity mismatch. Always 0 when PARITY_MODE=0.
overrun  out  1  one-cycle pulse: frame completed while holding register full; new frame dropped.
busy  out  1  FSM not in IDLE.
rx_idle  out  1  no start bit seen for GAP_BITS bit-times.
rx_eop  out  1  one-cycle pulse on the rising edge of rx_idle, only if at least one frame was received since the last rx_eop.

Behaviour:
- Reset: all flops clear asynchronously. rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, rx_idle=0, rx_eop=0. Sync chain resets to 1 and filter to 1. FSM resets to IDLE.
- Tick: phase accumulator, width ACC_W=16, increment round(BAUD*OVERSAMPLE*2^16/CLK_FREQ). tick=carry out, giving at most one tick per clk.
- Input conditioning: 2-flop synchroniser on clk, then a 3-tap majority filter updated on tick. rxf is the filtered bit. Latency rxd to rxf: 2 clk + 3 ticks max.
- Sample counter scnt, log2(OVERSAMPLE) bits, advances on tick. Sample point is scnt==OVERSAMPLE/2-1 after start sync.
- FSM states and transitions:
  - IDLE: on rxf==0, scnt<=0, go to START.
  - START: at sample point, rxf==1 is a false start: return to IDLE, no status. Else bit counter <= 0, scnt restarts, go to DATA.
  - DATA: sample every OVERSAMPLE ticks. Shift right into shreg[DATA_BITS-1:0]. After DATA_BITS samples go to PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: sample p. Error if (^data ^ p) != (PARITY_MODE==2).
  - STOP: sample STOP_BITS bits; any low sets frame error. After the last stop sample go to DONE.
  - DONE: one clk. Load the holding register if empty or if rx_ready is high the same cycle; else pulse overrun and discard. Return to IDLE.
- Simultaneous DONE and consumer accept: the word is replaced, with no overrun.
- Frames with errors are delivered with their flags; flags change only when a word loads.
- rx_valid clears on transfer unless a new word loads that cycle.
- Break (line held low): frame_err word of 0. FSM then waits in IDLE until rxf returns high before re-arming.
- Gap counter counts ticks while in IDLE, saturating at GAP_BITS*OVERSAMPLE. It clears on leaving IDLE. rx_idle = saturated.
- Mid-frame reset: frame abandoned, no outputs asserted after release.

Decomposition:
- Package uart_pkg: parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD), FSM state enum, clog2 function, accumulator increment function.
- Sub-module uart_baud_tick: the phase accumulator, shared later with the transmitter.

Test Plan:
- Timing setup for all scenarios: CLK_FREQ=16e6, BAUD=1e6, OVERSAMPLE=16, so tick every clk and 16 clk per bit.
- 8N1, send 0xA5 with rx_ready=1 -> rx_valid pulses for 1 clk with rx_data=0xA5, no errors. Delivered 10 bit-times ±3 clk after the start edge.
- 7E1 (DATA_BITS=7, PARITY_MODE=1): send 0x41 with correct parity 0, then with parity 1 -> first word parity_err=0, second word 0x41 with parity_err=1.
- 8N2: send 0x3C with the second stop bit low -> rx_data=0x3C, frame_err=1. Then a 6-clk low glitch -> false start, no rx_valid, busy back to 0.
- Overrun: rx_ready=0, send 0x11 then 0x22 -> held word stays 0x11, one overrun pulse at the second DONE. Raise rx_ready -> 0x11 transfers.
- Gap: GAP_BITS=4, send one byte then idle -> rx_idle rises 64 clk after the stop sample, rx_eop one pulse. A further idle period gives no second pulse. Assert rst_n low mid-frame -> all outputs 0 and no valid after release.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, FSM state type and elaboration helpers for the UART blocks
package uart_pkg;

    localparam int ACC_W = 16;
    localparam int INC_W = ACC_W + 1;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_DONE
    } rx_state_e;

    function automatic int clog2(input longint unsigned v);
        int               r;
        longint unsigned  x;
        r = 0;
        x = 64'd1;
        while (x < v) begin
            x = x << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Rounded phase increment; one extra bit so a ratio of exactly 1 (tick every clk) is representable.
    function automatic logic [INC_W-1:0] acc_inc(input longint unsigned clk_freq,
                                                 input longint unsigned baud,
                                                 input longint unsigned ovs);
        longint unsigned num;
        num = baud * ovs * (64'd1 << ACC_W);
        return INC_W'((num + clk_freq / 2) / clk_freq);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - phase-accumulator oversampling tick generator, at most one tick per clk
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam logic [INC_W-1:0] INC = acc_inc(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE));

    logic [ACC_W-1:0] acc_q;
    logic             tick_q;
    logic [INC_W-1:0] sum_d;

    assign sum_d = {1'b0, acc_q} + INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= sum_d[ACC_W-1:0];
            tick_q <= sum_d[ACC_W];
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised async serial receiver with holding register and idle/end-of-packet detection
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ    = 25000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int GAP_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 rx_idle,
    output logic                 rx_eop
);

    localparam int SCNT_W  = clog2(64'(OVERSAMPLE));
    localparam int GAP_MAX = GAP_BITS * OVERSAMPLE;
    localparam int GAP_W   = clog2(64'(GAP_MAX + 1));

    localparam logic [SCNT_W-1:0] SAMP_MID  = SCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SCNT_W-1:0] SAMP_END  = SCNT_W'(OVERSAMPLE - 1);
    localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]        LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_FULL  = GAP_W'(GAP_MAX);
    localparam logic              ODD_PAR   = 1'(PARITY_MODE == PAR_ODD);

    if (OVERSAMPLE < 8 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_ovs
        $error("uart_rx_param: OVERSAMPLE must be a power of 2 and at least 8");
    end
    if (longint'(CLK_FREQ) < longint'(BAUD) * longint'(OVERSAMPLE)) begin : g_bad_clk
        $error("uart_rx_param: CLK_FREQ must be at least BAUD*OVERSAMPLE");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_par
        $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (GAP_BITS < 2 || GAP_BITS > 255) begin : g_bad_gap
        $error("uart_rx_param: GAP_BITS must be 2..255");
    end

    logic tick;

    uart_baud_tick #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    // Input conditioning: two-flop synchroniser, then a 3-tap majority vote clocked by tick.
    logic [1:0] sync_q;
    logic [2:0] filt_q;
    logic       rxf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            filt_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], rxd};
            if (tick) begin
                filt_q <= {filt_q[1:0], sync_q[1]};
            end
        end
    end

    assign rxf = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) | (filt_q[1] & filt_q[2]);

    rx_state_e              state_q;
    logic [SCNT_W-1:0]      scnt_q;
    logic [3:0]             bcnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic                   ferr_q;
    logic                   perr_q;
    logic                   armed_q;
    logic                   busy_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   fe_q;
    logic                   pe_q;
    logic                   ovr_q;

    // armed_q blocks a new start until the line has been seen high, so a held break yields one word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rxf) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        scnt_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (scnt_q == SAMP_MID) begin
                            if (rxf) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                scnt_q  <= '0;
                                bcnt_q  <= '0;
                                ferr_q  <= 1'b0;
                                perr_q  <= 1'b0;
                                state_q <= ST_DATA;
                            end
                        end else begin
                            scnt_q <= scnt_q + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == SAMP_END) begin
                            shreg_q <= {rxf, shreg_q[DATA_BITS-1:1]};
                            if (bcnt_q == LAST_DATA) begin
                                bcnt_q  <= '0;
                                state_q <= (PARITY_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == SAMP_END) begin
                            perr_q  <= ((^shreg_q) ^ rxf) != ODD_PAR;
                            state_q <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        scnt_q <= scnt_q + 1'b1;
                        if (scnt_q == SAMP_END) begin
                            if (!rxf) begin
                                ferr_q <= 1'b1;
                            end
                            if (bcnt_q == LAST_STOP) begin
                                state_q <= ST_DONE;
                            end else begin
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (!valid_q || rx_ready) begin
                        data_q  <= shreg_q;
                        fe_q    <= ferr_q;
                        pe_q    <= perr_q;
                        valid_q <= 1'b1;
                    end else begin
                        ovr_q <= 1'b1;
                    end
                    armed_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Line-gap detection: ticks spent in IDLE, saturating; end-of-packet only after a real frame.
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic             idle_q;
    logic             eop_q;
    logic             seen_q;
    logic             eop_d;

    always_comb begin
        gap_d = gap_q;
        if (state_q != ST_IDLE) begin
            gap_d = '0;
        end else if (tick && gap_q != GAP_FULL) begin
            gap_d = gap_q + 1'b1;
        end
    end

    assign eop_d = (gap_d == GAP_FULL) && !idle_q && seen_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_q  <= '0;
            idle_q <= 1'b0;
            eop_q  <= 1'b0;
            seen_q <= 1'b0;
        end else begin
            gap_q  <= gap_d;
            idle_q <= (gap_d == GAP_FULL);
            eop_q  <= eop_d;
            if (state_q == ST_DONE) begin
                seen_q <= 1'b1;
            end else if (eop_d) begin
                seen_q <= 1'b0;
            end
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = fe_q;
    assign parity_err = pe_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;
    assign rx_idle    = idle_q;
    assign rx_eop     = eop_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed self-checking bench for uart_rx_param across four configurations
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] rxd;
    logic [3:0] rdy;
    logic [7:0] d0, d2, d3;
    logic [6:0] d1;
    logic [3:0] vld, fe, pe, ov, bsy, idl, eop;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(1), .GAP_BITS(16)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]), .busy(bsy[0]), .rx_idle(idl[0]), .rx_eop(eop[0]));

    uart_rx_param #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(7),
                    .PARITY_MODE(1), .STOP_BITS(1), .GAP_BITS(16)) u_7e1 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]), .busy(bsy[1]), .rx_idle(idl[1]), .rx_eop(eop[1]));

    uart_rx_param #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(2), .GAP_BITS(16)) u_8n2 (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]), .busy(bsy[2]), .rx_idle(idl[2]), .rx_eop(eop[2]));

    uart_rx_param #(.CLK_FREQ(16000000), .BAUD(1000000), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(1), .GAP_BITS(4)) u_gap (
        .clk(clk), .rst_n(rst_n), .rxd(rxd[3]), .rx_data(d3), .rx_valid(vld[3]), .rx_ready(rdy[3]),
        .frame_err(fe[3]), .parity_err(pe[3]), .overrun(ov[3]), .busy(bsy[3]), .rx_idle(idl[3]), .rx_eop(eop[3]));

    int ntests = 0;
    int nfail  = 0;

    int         cyc_now = 0;
    int         vcnt[4]         = '{default: 0};
    int         ovcnt[4]        = '{default: 0};
    int         eopcnt[4]       = '{default: 0};
    int         vrise_at[4]     = '{default: 0};
    int         idle_rise_at[4] = '{default: 0};
    logic [3:0] vld_prev = '0;
    logic [3:0] idl_prev = '0;

    always @(negedge clk) begin
        cyc_now++;
        for (int i = 0; i < 4; i++) begin
            if (vld[i] && !vld_prev[i]) begin
                vcnt[i]++;
                vrise_at[i] = cyc_now;
            end
            if (idl[i] && !idl_prev[i]) idle_rise_at[i] = cyc_now;
            if (ov[i]) ovcnt[i]++;
            if (eop[i]) eopcnt[i]++;
        end
        vld_prev = vld;
        idl_prev = idl;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] get_data(input int ch);
        case (ch)
            0:       return {1'b0, d0};
            1:       return {2'b0, d1};
            2:       return {1'b0, d2};
            default: return {1'b0, d3};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input int ch, input logic [8:0] data, input int nb, input bit has_par,
                              input logic p, input int nstop, input logic [1:0] stopv);
        rxd[ch] = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            rxd[ch] = data[i];
            repeat (16) @(negedge clk);
        end
        if (has_par) begin
            rxd[ch] = p;
            repeat (16) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            rxd[ch] = stopv[i];
            repeat (16) @(negedge clk);
        end
        rxd[ch] = 1'b1;
    endtask

    task automatic wait_valid(input int ch, input int budget, output int cyc, output bit ok,
                              output logic [8:0] dat, output logic f, output logic p, output logic nextv);
        ok = 1'b0;
        cyc = 0;
        dat = '0;
        f = 1'b0;
        p = 1'b0;
        nextv = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (vld[ch]) begin
                ok  = 1'b1;
                dat = get_data(ch);
                f   = fe[ch];
                p   = pe[ch];
            end
        end
        if (ok) begin
            @(negedge clk);
            nextv = vld[ch];
        end
    endtask

    typedef struct {
        int         ch;
        logic [8:0] data;
        int         nb;
        bit         has_par;
        logic       p;
        int         nstop;
        logic [1:0] stopv;
        logic [8:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int         cyc;
        bit         ok;
        logic [8:0] dat;
        logic       f, p, nextv;
        int         base, base2;
        bit         saw;

        vecs[0] = '{0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b01, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h000, 8, 1'b0, 1'b0, 1, 2'b01, 9'h000, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h0FF, 8, 1'b0, 1'b0, 1, 2'b00, 9'h0FF, 1'b1, 1'b0};
        vecs[3] = '{1, 9'h041, 7, 1'b1, 1'b0, 1, 2'b01, 9'h041, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h041, 7, 1'b1, 1'b1, 1, 2'b01, 9'h041, 1'b0, 1'b1};
        vecs[5] = '{1, 9'h007, 7, 1'b1, 1'b1, 1, 2'b01, 9'h007, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h007, 7, 1'b1, 1'b0, 1, 2'b01, 9'h007, 1'b0, 1'b1};
        vecs[7] = '{2, 9'h03C, 8, 1'b0, 1'b0, 2, 2'b01, 9'h03C, 1'b1, 1'b0};
        vecs[8] = '{2, 9'h03C, 8, 1'b0, 1'b0, 2, 2'b11, 9'h03C, 1'b0, 1'b0};
        vecs[9] = '{2, 9'h081, 8, 1'b0, 1'b0, 2, 2'b10, 9'h081, 1'b1, 1'b0};

        rst_n = 1'b0;
        rxd   = 4'hF;
        rdy   = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_valid", 32'(vld), 0);
        check("reset_busy", 32'(bsy), 0);
        check("reset_idle", 32'(idl), 0);
        check("reset_eop", 32'(eop), 0);
        check("reset_overrun", 32'(ov), 0);
        check("reset_flags", 32'({fe, pe}), 0);
        check("reset_data", 32'({d0, d1, d2, d3}), 0);
        rst_n = 1'b1;

        repeat (300) @(negedge clk);
        check("idle_after_reset_gap4", 32'(idl[3]), 1);
        check("idle_after_reset_gap16", 32'(idl[0]), 1);
        check("no_eop_without_frame", 32'(eopcnt[3] + eopcnt[0]), 0);

        for (int k = 0; k < 10; k++) begin
            fork
                send_frame(vecs[k].ch, vecs[k].data, vecs[k].nb, vecs[k].has_par, vecs[k].p,
                           vecs[k].nstop, vecs[k].stopv);
                wait_valid(vecs[k].ch, 400, cyc, ok, dat, f, p, nextv);
            join
            check($sformatf("vec%0d_valid_seen", k), 32'(ok), 1);
            check($sformatf("vec%0d_data", k), 32'(dat), 32'(vecs[k].exp_d));
            check($sformatf("vec%0d_frame_err", k), 32'(f), 32'(vecs[k].exp_fe));
            check($sformatf("vec%0d_parity_err", k), 32'(p), 32'(vecs[k].exp_pe));
            check($sformatf("vec%0d_valid_one_clk", k), 32'(nextv), 0);
            if (k == 0) check("vec0_latency_157_to_163", 32'(cyc >= 157 && cyc <= 163), 1);
            repeat (40) @(negedge clk);
        end
        check("no_overrun_with_ready", 32'(ovcnt[0] + ovcnt[1] + ovcnt[2]), 0);

        base = vcnt[2];
        saw  = 1'b0;
        rxd[2] = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 6) rxd[2] = 1'b1;
            @(negedge clk);
            if (bsy[2]) saw = 1'b1;
        end
        check("glitch_busy_seen", 32'(saw), 1);
        check("glitch_busy_cleared", 32'(bsy[2]), 0);
        repeat (200) @(negedge clk);
        check("glitch_no_valid", 32'(vcnt[2] - base), 0);

        base = vcnt[0];
        rxd[0] = 1'b0;
        fork
            begin
                repeat (192) @(negedge clk);
                rxd[0] = 1'b1;
            end
            wait_valid(0, 400, cyc, ok, dat, f, p, nextv);
        join
        check("break_valid_seen", 32'(ok), 1);
        check("break_data_zero", 32'(dat), 0);
        check("break_frame_err", 32'(f), 1);
        repeat (300) @(negedge clk);
        check("break_single_word", 32'(vcnt[0] - base), 1);
        check("break_busy_clear", 32'(bsy[0]), 0);

        rdy[0] = 1'b0;
        base = ovcnt[0];
        fork
            send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 2'b01);
            wait_valid(0, 400, cyc, ok, dat, f, p, nextv);
        join
        check("ovr_first_valid", 32'(ok), 1);
        check("ovr_first_held", 32'(nextv), 1);
        check("ovr_first_data", 32'(dat), 32'h11);
        repeat (20) @(negedge clk);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 2'b01);
        repeat (20) @(negedge clk);
        check("ovr_pulse_count", 32'(ovcnt[0] - base), 1);
        check("ovr_still_valid", 32'(vld[0]), 1);
        check("ovr_held_data", 32'(d0), 32'h11);
        rdy[0] = 1'b1;
        @(negedge clk);
        check("ovr_transferred", 32'(vld[0]), 0);
        repeat (40) @(negedge clk);

        base = eopcnt[3];
        fork
            send_frame(3, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b01);
            wait_valid(3, 400, cyc, ok, dat, f, p, nextv);
            begin
                repeat (80) @(negedge clk);
                saw = idl[3];
            end
        join
        check("gap_idle_low_mid_frame", 32'(saw), 0);
        check("gap_data", 32'(dat), 32'h5A);
        repeat (150) @(negedge clk);
        check("gap_idle_high", 32'(idl[3]), 1);
        check("gap_delay_60_to_68", 32'((idle_rise_at[3] - vrise_at[3]) >= 60 &&
                                        (idle_rise_at[3] - vrise_at[3]) <= 68), 1);
        check("gap_one_eop", 32'(eopcnt[3] - base), 1);
        base2 = idle_rise_at[3];
        rxd[3] = 1'b0;
        repeat (6) @(negedge clk);
        rxd[3] = 1'b1;
        repeat (150) @(negedge clk);
        check("gap_idle_rerose", 32'(idle_rise_at[3] != base2 && idl[3]), 1);
        check("gap_no_second_eop", 32'(eopcnt[3] - base), 1);

        base = vcnt[0];
        rxd[0] = 1'b0;
        repeat (16) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (16) @(negedge clk);
        rxd[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("midframe_busy_before_reset", 32'(bsy[0]), 1);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'({vld[0], bsy[0], idl[0], eop[0], ov[0], fe[0], pe[0]}), 0);
        check("midframe_reset_data", 32'(d0), 0);
        @(negedge clk);
        rxd[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midframe_no_valid_after_release", 32'(vcnt[0] - base), 0);
        check("midframe_busy_after_release", 32'(bsy[0]), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
